// File: rtl/gci_node_irq_req_pkg.sv
// Shared constants and helpers for the per-node GCI interrupt request front end.
package gci_node_irq_req_pkg;

    localparam int GCI_IRQ_FIFO_DEPTH   = 8;
    localparam int GCI_IRQ_FIFO_DEPTH_N = 3;
    localparam int GCI_IRQ_CAUSE_W      = 8;
    localparam int GCI_IRQ_OVF_W        = 8;

    // Statistics counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [GCI_IRQ_OVF_W-1:0] satInc(input logic [GCI_IRQ_OVF_W-1:0] value);
        return (&value) ? value : value + GCI_IRQ_OVF_W'(1);
    endfunction

endpackage

// File: rtl/gci_node_irq_req_if.sv
// Device-event and arbiter handshake bundle between a GCI node and its IRQ front end.
interface gci_node_irq_req_if #(
    parameter int CAUSE_W = 8
);

    logic               devIrqReq;
    logic [CAUSE_W-1:0] devIrqCause;
    logic               nodeIrqBusy;
    logic               nodeIrq;
    logic               nodeAck;

    modport master (
        output devIrqReq,
        output devIrqCause,
        output nodeIrqBusy,
        output nodeAck,
        input  nodeIrq
    );

    modport slave (
        input  devIrqReq,
        input  devIrqCause,
        input  nodeIrqBusy,
        input  nodeAck,
        output nodeIrq
    );

endinterface

// File: rtl/gci_irq_cause_fifo.sv
// Circular DEPTH x CAUSE_W cause buffer with a separate occupancy counter.
// The caller guarantees push is never issued when full without a pop, nor pop when empty.
module gci_irq_cause_fifo
    import gci_node_irq_req_pkg::*;
#(
    parameter int DEPTH   = GCI_IRQ_FIFO_DEPTH,
    parameter int DEPTH_N = GCI_IRQ_FIFO_DEPTH_N,
    parameter int CAUSE_W = GCI_IRQ_CAUSE_W
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [CAUSE_W-1:0] wrData,
    output logic [CAUSE_W-1:0] rdData,
    output logic [DEPTH_N:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [DEPTH_N:0] FullCount = (DEPTH_N+1)'(DEPTH);

    logic [CAUSE_W-1:0] mem [DEPTH];
    logic [DEPTH_N-1:0] wrPtr;
    logic [DEPTH_N-1:0] rdPtr;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + DEPTH_N'(1);
            if (pop)  rdPtr <= rdPtr + DEPTH_N'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_N+1)'(1);
                2'b01:   count <= count - (DEPTH_N+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge iCLOCK) begin
        if (push && !flush) mem[wrPtr] <= wrData;
    end

    assign rdData = mem[rdPtr];
    assign full   = (count == FullCount);
    assign empty  = (count == '0);

endmodule

// File: rtl/gci_node_irq_req.sv
// Per-node IRQ request front end: queues device causes, raises a level request to the
// GCI arbiter and pops one cause per grant, keeping last-cause and overflow statistics.
module gci_node_irq_req
    import gci_node_irq_req_pkg::*;
#(
    parameter int DEPTH   = GCI_IRQ_FIFO_DEPTH,
    parameter int DEPTH_N = GCI_IRQ_FIFO_DEPTH_N,
    parameter int CAUSE_W = GCI_IRQ_CAUSE_W
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iCTRL_ENABLE,
    input  logic                     iCTRL_FLUSH,
    gci_node_irq_req_if.slave        bus,
    output logic [CAUSE_W-1:0]       oLAST_CAUSE,
    output logic                     oLAST_CAUSE_VALID,
    output logic [DEPTH_N:0]         oPENDING_COUNT,
    output logic                     oOVERFLOW,
    output logic [GCI_IRQ_OVF_W-1:0] oOVERFLOW_COUNT
);

    logic               fifoFull;
    logic               fifoEmpty;
    logic [CAUSE_W-1:0] headCause;
    logic               popNow;
    logic               pushNow;
    logic               dropNow;

    // Flush wins over everything; a pop frees a slot so a full queue can still accept.
    always_comb begin
        bus.nodeIrq = !fifoEmpty && iCTRL_ENABLE && !bus.nodeIrqBusy;
        popNow      = bus.nodeAck && bus.nodeIrq && !iCTRL_FLUSH;
        pushNow     = bus.devIrqReq && (!fifoFull || popNow) && !iCTRL_FLUSH;
        dropNow     = bus.devIrqReq && fifoFull && !popNow && !iCTRL_FLUSH;
    end

    gci_irq_cause_fifo #(
        .DEPTH   (DEPTH),
        .DEPTH_N (DEPTH_N),
        .CAUSE_W (CAUSE_W)
    ) causeFifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .push    (pushNow),
        .pop     (popNow),
        .flush   (iCTRL_FLUSH),
        .wrData  (bus.devIrqCause),
        .rdData  (headCause),
        .count   (oPENDING_COUNT),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    // A flush only invalidates the last cause; the stale value stays visible.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oLAST_CAUSE       <= '0;
            oLAST_CAUSE_VALID <= 1'b0;
        end else if (iCTRL_FLUSH) begin
            oLAST_CAUSE_VALID <= 1'b0;
        end else if (popNow) begin
            oLAST_CAUSE       <= headCause;
            oLAST_CAUSE_VALID <= 1'b1;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oOVERFLOW       <= 1'b0;
            oOVERFLOW_COUNT <= '0;
        end else if (iCTRL_FLUSH) begin
            oOVERFLOW       <= 1'b0;
            oOVERFLOW_COUNT <= '0;
        end else if (dropNow) begin
            oOVERFLOW       <= 1'b1;
            oOVERFLOW_COUNT <= satInc(oOVERFLOW_COUNT);
        end
    end

endmodule

// File: doc/gci_node_irq_req.md
Name: gci_node_irq_req

Overview:
Per-node interrupt request front end that sits directly upstream of the GCI IRQ arbiter; one instance per GCI node, driving iNODEn_IRQ and consuming oNODEn_ACK.
- Captures device interrupt events together with an 8-bit cause code and buffers them in a small FIFO.
- Holds a level request toward the arbiter while events are pending, and pops exactly one event per arbiter acknowledge.
- Keeps the last acknowledged cause and overflow statistics for node-register readback.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
DEPTH_N, 3, log2(DEPTH)
CAUSE_W, 8, cause code width

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iCTRL_ENABLE  in  1  request enable; 0 masks oNODE_IRQ and leaves queue contents intact
iCTRL_FLUSH  in  1  single-cycle pulse; empties queue and clears overflow flag/counter
iDEV_IRQ_REQ  in  1  device event strobe, one event per high cycle
iDEV_IRQ_CAUSE  in  CAUSE_W  cause code qualified by iDEV_IRQ_REQ
iNODE_IRQ_BUSY  in  1  arbiter busy (node info invalid); masks oNODE_IRQ
oNODE_IRQ  out  1  request to arbiter
iNODE_ACK  in  1  arbiter grant pulse; pops queue head
oLAST_CAUSE  out  CAUSE_W  cause of the most recently acknowledged event
oLAST_CAUSE_VALID  out  1  set on first ack after reset/flush
oPENDING_COUNT  out  DEPTH_N+1  current number of queued entries
oOVERFLOW  out  1  sticky; an event was dropped
oOVERFLOW_COUNT  out  8  dropped events, saturating at 8'hFF

Behaviour:
- Reset (async, inRESET low):
  - Read and write pointers and count go to 0.
  - oNODE_IRQ=0, oLAST_CAUSE=0, oLAST_CAUSE_VALID=0, oPENDING_COUNT=0, oOVERFLOW=0, oOVERFLOW_COUNT=0.
  - FIFO storage is not reset.
- Storage: circular buffer with DEPTH_N-bit read/write pointers that wrap modulo DEPTH. A separate count register runs 0..DEPTH; full is count==DEPTH and empty is count==0.
- Push: an event is accepted at a clock edge when iDEV_IRQ_REQ=1 and either the queue is not full or a pop occurs in the same cycle. A push while full with no pop is dropped, sets oOVERFLOW, and increments oOVERFLOW_COUNT, saturating at FF.
- Request: oNODE_IRQ = (count!=0) && iCTRL_ENABLE && !iNODE_IRQ_BUSY. It is combinational from registered count, so the request appears 1 cycle after the first push.
- Pop: occurs when iNODE_ACK=1 && oNODE_IRQ=1. On a pop:
  - oLAST_CAUSE <= head cause and oLAST_CAUSE_VALID <= 1.
  - The read pointer advances.
  - An ack while oNODE_IRQ=0 is ignored and causes no state change.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full: the entry is freed, the new event is accepted, and no overflow is recorded. When empty, the push is stored but cannot be popped in the same cycle, because oNODE_IRQ is 0 at that point.
- Flush priority: iCTRL_FLUSH overrides push and pop in the same cycle.
  - Pointers, count and overflow state are cleared, and oLAST_CAUSE_VALID is cleared.
  - A simultaneous device event is discarded and not counted as an overflow.
  - A simultaneous ack does not update oLAST_CAUSE.
- Masking: while iCTRL_ENABLE=0 or iNODE_IRQ_BUSY=1, the queue still accepts pushes; only the request is masked.
- Multiple pending entries: oNODE_IRQ stays high after a pop while count!=0. The arbiter's own ack-wait state paces subsequent grants, and this block needs no extra handshake.
- oPENDING_COUNT reflects the count register directly.

Decomposition:
- Shared package constants:
  - default depth and cause width (GCI_IRQ_FIFO_DEPTH, GCI_IRQ_CAUSE_W)
  - overflow counter width (GCI_IRQ_OVF_W=8)
- One natural sub-module, gci_irq_cause_fifo: a synchronous DEPTH x CAUSE_W FIFO with push/pop/flush, count, full and empty. The top module adds the request gating, the last-cause register and the overflow statistics.

Test Plan:
1. After reset, push cause 8'h5A with enable=1 and busy=0 -> the next cycle gives oNODE_IRQ=1, oPENDING_COUNT=1. Ack 1 cycle -> oLAST_CAUSE=5A, oLAST_CAUSE_VALID=1, count=0, oNODE_IRQ=0.
2. Push 9 events (causes 1..9) with no ack, DEPTH=8 -> count=8, oOVERFLOW=1, oOVERFLOW_COUNT=1. Then 8 acks -> oLAST_CAUSE sequence 1..8, in order across pointer wrap.
3. Queue full, and push cause 8'hAA in the same cycle as an ack -> count stays 8, no overflow increment, 8'hAA dequeued last.
4. Enable=0 with 3 pushes -> oNODE_IRQ=0 and count=3. Set enable=1 -> oNODE_IRQ=1 the same cycle. Busy=1 -> oNODE_IRQ=0. Ack during busy -> count unchanged.
5. Flush asserted with a simultaneous push and ack while count=4 and overflow=1 -> count=0, oOVERFLOW=0, oOVERFLOW_COUNT=0, oLAST_CAUSE_VALID=0, oNODE_IRQ=0 the next cycle.
6. Push 300 events with the queue full and no acks -> oOVERFLOW_COUNT saturates at FF. Assert inRESET low mid-stream -> all outputs return to 0 asynchronously.
